// File: rtl/dmem_access_unit.sv
// Memory-stage data memory responder with configurable wait states.
// Optional misaligned-access rejection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_access_unit #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        R_in,
  input  logic        W_in,
  input  logic        WE_in,
  output logic        stall_out,
  output logic [31:0] wb_data_out,
  output logic        wb_we_out,
  output logic        err_misalign_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        is_store_q;
  logic        we_q;
  logic [31:0] mem [DEPTH];

  logic          req;
  logic          misaligned;
  logic [AW-1:0] idx;

  assign req = R_in || W_in;
  assign idx = addr_q[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  assign misaligned = (addr_in[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state == IDLE) && req && misaligned;
  end

  assign err_misalign_out = err_q;
`else
  assign misaligned       = 1'b0;
  assign err_misalign_out = 1'b0;
`endif

  // Rejected (misaligned) requests never stall; RESP never stalls.
  assign stall_out = ((state == IDLE) && req && !misaligned) || (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_store_q  <= 1'b0;
      we_q        <= 1'b0;
      wb_data_out <= '0;
      wb_we_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!req) begin
            wb_data_out <= addr_in;
            wb_we_out   <= WE_in;
          end else if (misaligned) begin
            wb_data_out <= addr_in;
            wb_we_out   <= 1'b0;
          end else begin
            addr_q     <= addr_in;
            wdata_q    <= wdata_in;
            is_store_q <= W_in;
            we_q       <= WE_in;
            cnt        <= 4'(WAIT_CYCLES);
            wb_we_out  <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (is_store_q) begin
              wb_data_out <= addr_q;
              wb_we_out   <= 1'b0;
            end else begin
              wb_data_out <= mem[idx];
              wb_we_out   <= we_q;
            end
            state <= RESP;
          end
        end
        RESP: begin
          wb_we_out <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is never cleared; a store on a reset edge is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && (state == BUSY) && (cnt == '0) && is_store_q)
      mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: transaction-level model plus
// directed literal checks of the store/load, pass-through, wrap and reset cases.
module tb_dmem_access_unit;

  localparam int DEPTH = 256;
  localparam int WAIT  = 2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_in, wdata_in;
  logic        R_in, W_in, WE_in;
  logic        stall_out, wb_we_out, err_misalign_out;
  logic [31:0] wb_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_access_unit #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .wdata_in(wdata_in),
    .R_in(R_in), .W_in(W_in), .WE_in(WE_in), .stall_out(stall_out),
    .wb_data_out(wb_data_out), .wb_we_out(wb_we_out),
    .err_misalign_out(err_misalign_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted request at cycle c0 stalls through
  // c0+WAIT+1, accesses memory at the end of that cycle, responds at c0+WAIT+2.
  logic [31:0] m_mem [int];
  int          cyc = 0;
  int          c0 = 0;
  bit          busy = 0;
  bit          chk_en = 0;
  logic [31:0] m_addr, m_wdata;
  bit          m_store, m_we;
  logic [31:0] exp_data;
  logic        exp_we, exp_err;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  always @(posedge clk) begin
    exp_err = 1'b0;
    if (rst) begin
      exp_data = '0;
      exp_we   = 1'b0;
      busy     = 0;
    end else if (busy) begin
      if (cyc == c0 + WAIT + 1) begin
        if (m_store) begin
          m_mem[widx(m_addr)] = m_wdata;
          exp_data = m_addr;
          exp_we   = 1'b0;
        end else begin
          exp_data = m_mem.exists(widx(m_addr)) ? m_mem[widx(m_addr)] : 'x;
          exp_we   = m_we;
        end
      end else if (cyc == c0 + WAIT + 2) begin
        exp_we = 1'b0;
        busy   = 0;
      end
    end else if (R_in || W_in) begin
      if (CHK && addr_in[1:0] != 2'b00) begin
        exp_err  = 1'b1;
        exp_we   = 1'b0;
        exp_data = addr_in;
      end else begin
        busy    = 1;
        c0      = cyc;
        m_addr  = addr_in;
        m_wdata = wdata_in;
        m_store = W_in;
        m_we    = WE_in;
        exp_we  = 1'b0;
      end
    end else begin
      exp_data = addr_in;
      exp_we   = WE_in;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_stall;
      if (busy) exp_stall = (cyc <= c0 + WAIT + 1);
      else      exp_stall = (R_in || W_in) && !(CHK && addr_in[1:0] != 2'b00);
      check("model_stall", 32'(stall_out), 32'(exp_stall));
      check("model_wb_data", wb_data_out, exp_data);
      check("model_wb_we", 32'(wb_we_out), 32'(exp_we));
      check("model_err", 32'(err_misalign_out), 32'(exp_err));
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic w, input logic we);
    addr_in = a; wdata_in = d; R_in = r; W_in = w; WE_in = we;
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Issues one memory instruction and returns what the RESP cycle shows.
  task automatic mem_op(input logic [31:0] a, input logic [31:0] d,
                        input logic r, input logic w, input logic we,
                        output int stalls, output logic [31:0] rd, output logic rwe);
    bit done = 0;
    drive(a, d, r, w, we);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall_out) begin
        done = 1;
        break;
      end
      stalls++;
    end
    if (!done) check("stall_timeout", 32'(stall_out), 32'h0);
    rd  = wb_data_out;
    rwe = wb_we_out;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int          st;
    logic [31:0] rd;
    logic        rwe;

    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_stall", 32'(stall_out), 32'h0);
    check("reset_wb_data", wb_data_out, 32'h0);
    check("reset_wb_we", 32'(wb_we_out), 32'h0);
    check("reset_err", 32'(err_misalign_out), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    mem_op(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, st, rd, rwe);
    check("store_stall_cycles", 32'(st), 32'd4);
    check("store_wb_we", 32'(rwe), 32'h0);

    mem_op(32'h10, 32'h0, 1'b1, 1'b0, 1'b1, st, rd, rwe);
    check("load_stall_cycles", 32'(st), 32'd4);
    check("load_data", rd, 32'hDEADBEEF);
    check("load_wb_we", 32'(rwe), 32'h1);
    @(negedge clk);
    check("load_wb_we_one_cycle", 32'(wb_we_out), 32'h0);
    @(posedge clk); #1;

    for (int v = 1; v <= 3; v++) begin
      drive(32'(v), 32'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("pass_stall", 32'(stall_out), 32'h0);
      @(posedge clk); #1;
      check("pass_data", wb_data_out, 32'(v));
      check("pass_we", 32'(wb_we_out), 32'h1);
    end
    idle();
    @(posedge clk); #1;

    mem_op(32'h400, 32'h55, 1'b0, 1'b1, 1'b0, st, rd, rwe);
    mem_op(32'h0, 32'h0, 1'b1, 1'b0, 1'b1, st, rd, rwe);
    check("wrap_load", rd, 32'h55);

    mem_op(32'h30, 32'h99, 1'b1, 1'b1, 1'b1, st, rd, rwe);
    check("prio_wb_we", 32'(rwe), 32'h0);
    check("prio_wb_data", rd, 32'h30);
    mem_op(32'h30, 32'h0, 1'b1, 1'b0, 1'b1, st, rd, rwe);
    check("prio_load", rd, 32'h99);

    mem_op(32'h20, 32'h77, 1'b0, 1'b1, 1'b0, st, rd, rwe);
    drive(32'h20, 32'h0BAD, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy_stall", 32'(stall_out), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_stall", 32'(stall_out), 32'h0);
    @(posedge clk); #1;
    mem_op(32'h20, 32'h0, 1'b1, 1'b0, 1'b1, st, rd, rwe);
    check("midrst_retained", rd, 32'h77);

`ifdef DMEM_ALIGN_CHECK_EN
    drive(32'h13, 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("misalign_stall", 32'(stall_out), 32'h0);
    @(posedge clk); #1;
    idle();
    check("misalign_err", 32'(err_misalign_out), 32'h1);
    check("misalign_wb_we", 32'(wb_we_out), 32'h0);
    check("misalign_wb_data", wb_data_out, 32'h13);
    @(posedge clk); #1;
    check("misalign_err_pulse", 32'(err_misalign_out), 32'h0);
    mem_op(32'h10, 32'h0, 1'b1, 1'b0, 1'b1, st, rd, rwe);
    check("misalign_mem_unchanged", rd, 32'hDEADBEEF);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage responder that consumes the request side of the EX/MEM pipeline register: ALU result as address, `DR2` as store data, `W`/`R` as store/load strobes, `WE` as register-writeback enable. It owns a word-addressed data memory with a configurable wait-state latency. It stalls upstream while an access is in flight. It presents a registered writeback result (load data or pass-through ALU value) to the MEM/WB stage.

## Interface
- `DEPTH`, 256: data memory depth in 32-bit words (power of two).
- `WAIT_CYCLES`, 2: extra wait states per access, range 0..15.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `addr_in` in 32: byte address (ALU result).
- `wdata_in` in 32: store data (`DR2`).
- `R_in` in 1: load request.
- `W_in` in 1: store request.
- `WE_in` in 1: register-writeback enable of the instruction.
- `stall_out` out 1: hold upstream pipeline registers (combinational).
- `wb_data_out` out 32: writeback value (registered).
- `wb_we_out` out 1: writeback enable, one-cycle qualified (registered).
- `err_misalign_out` out 1: misaligned-access pulse (registered; see Configuration).

## Operation
- FSM states: IDLE, BUSY, RESP. A 4-bit wait counter `cnt` and latched `addr`/`wdata`/`is_store`/`we` registers support the FSM.
- IDLE, no request (`R_in`=`W_in`=0):
  - Each edge registers `wb_data_out`<=`addr_in` and `wb_we_out`<=`WE_in`.
  - State stays IDLE.
- IDLE, request present:
  - Latch inputs.
  - `is_store`=`W_in`. `W_in` has priority when both strobes are high, so that case is a store.
  - `cnt`<=`WAIT_CYCLES`, go BUSY.
  - `wb_we_out`<=0.
- BUSY, `cnt`!=0: `cnt`<=`cnt`-1.
- BUSY, `cnt`==0: perform the access at this edge, then go RESP.
  - Store: `mem[idx]`<=`wdata`; `wb_data_out`<=latched address; `wb_we_out`<=0.
  - Load: `wb_data_out`<=`mem[idx]`; `wb_we_out`<=latched `we`.
- RESP: always go IDLE. Inputs are ignored, because they still carry the completed request. Next edge `wb_we_out`<=0.
- `idx` = `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH` words.
- `stall_out` = (IDLE && (`R_in`||`W_in`)) || BUSY. It is low in RESP.
- Reset:
  - State IDLE, `cnt`=0.
  - `wb_data_out`=0, `wb_we_out`=0, `err_misalign_out`=0, latched registers 0.
  - Memory contents are not cleared.
- Reset mid-operation: returns to IDLE. A store whose access edge coincides with or follows reset is not performed.

## Timing
- Request first presented in cycle C0: `stall_out` is high in C0 through C0+`WAIT_CYCLES`+1.
- RESP is cycle C0+`WAIT_CYCLES`+2: `wb_*` valid, `stall_out` low.
- Total occupancy is `WAIT_CYCLES`+3 cycles per memory instruction.
- With `WAIT_CYCLES`=0: stall in C0 and C1; response in C2.
- Non-memory instructions: one-cycle latency, zero stall, back-to-back every cycle.
- Back-to-back memory instructions: the second one is seen in IDLE one cycle after RESP, and its stall starts then.
- `wb_we_out` is never high for more than one cycle per instruction.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: a request in IDLE with `addr_in[1:0]`!=0 is rejected.
  - No BUSY, no memory access, `stall_out`=0.
  - Next edge: `err_misalign_out`<=1 for exactly one cycle; `wb_we_out`<=0; `wb_data_out`<=`addr_in`.
- Undefined: `addr_in[1:0]` is ignored (access uses the word index). `err_misalign_out` is tied to 0.

## Test plan
- Reset, then idle: `rst`=1 for 2 cycles -> all outputs 0, `stall_out`=0 with no request.
- Store then load, `WAIT_CYCLES`=2:
  - Store `addr_in`=0x10, `wdata_in`=0xDEADBEEF -> `stall_out` high 4 cycles, `wb_we_out`=0.
  - Load 0x10 with `WE_in`=1 -> RESP shows `wb_data_out`=0xDEADBEEF, `wb_we_out`=1 for one cycle.
- Pass-through: three consecutive ALU instructions, values 1, 2, 3 with `WE_in`=1 -> `wb_data_out` 1, 2, 3 on consecutive cycles, no stall.
- Wrap and priority, `DEPTH`=256:
  - Store 0x55 at byte address 0x400 -> a load at 0x0 returns 0x55.
  - `R_in`=`W_in`=1 -> treated as a store, `wb_we_out`=0.
- Reset mid-store: assert `rst` in BUSY before the access edge -> location retains its prior value, state IDLE.
- With `DMEM_ALIGN_CHECK_EN`: load at 0x13 -> `err_misalign_out`=1 for one cycle, no stall, `wb_we_out`=0, memory unchanged.
